// File: rtl/regfile_sb_if.sv
// Register-file bus: read ports, writeback, reservation and flush signals.
// master drives requests (issue/writeback side); slave is the register file.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                rsv_ok;
   logic                flush;
   logic [AW:0]         busy_cnt;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      input  rd_data, rd_busy, rsv_ok, busy_cnt
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
      output rd_data, rd_busy, rsv_ok, busy_cnt
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with busy-bit scoreboard: 0-cycle reads (optional write bypass), 1-cycle write/reserve.
// No stall of its own: a rejected reservation (rsv_ok=0) must be retried by the requester.
module regfile_sb #(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   regfile_sb_if.slave bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] busy;
   logic [AW:0]     busy_cnt_q;

   logic wr_eff;
   logic rsv_zero;
   logic rsv_ok;
   logic rsv_set;
   logic wr_clr;

   assign wr_eff   = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
   assign rsv_zero = (ZERO_REG != 0) && (bus.rsv_addr == '0);
   assign rsv_ok   = !busy[bus.rsv_addr] || rsv_zero;
   // Flush discards a concurrent reservation; zero-reg reservations are accepted but tracked nowhere.
   assign rsv_set  = bus.rsv_en && rsv_ok && !rsv_zero && !bus.flush;
   assign wr_clr   = wr_eff && busy[bus.wr_addr];

   assign bus.rsv_ok   = rsv_ok;
   assign bus.busy_cnt = busy_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NREG; k++) rf[k] <= '0;
      end else if (wr_eff) begin
         rf[bus.wr_addr] <= bus.wr_data;
      end
   end

   // rsv_set implies the target was idle, so it never collides with wr_clr on the same bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy       <= '0;
         busy_cnt_q <= '0;
      end else if (bus.flush) begin
         busy       <= '0;
         busy_cnt_q <= '0;
      end else begin
         if (wr_clr)  busy[bus.wr_addr]  <= 1'b0;
         if (rsv_set) busy[bus.rsv_addr] <= 1'b1;
         case ({rsv_set, wr_clr})
            2'b10:   busy_cnt_q <= busy_cnt_q + (AW+1)'(1);
            2'b01:   busy_cnt_q <= busy_cnt_q - (AW+1)'(1);
            default: busy_cnt_q <= busy_cnt_q;
         endcase
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = bus.rd_addr[i*AW +: AW];

      always_comb begin
         data = '0;
         bsy  = 1'b0;
         if (bus.rd_en[i]) begin
            if ((ZERO_REG != 0) && (addr == '0)) begin
               data = '0;
            end else if ((BYPASS != 0) && wr_eff && (bus.wr_addr == addr)) begin
               data = bus.wr_data;
            end else begin
               data = rf[addr];
               bsy  = busy[addr];
            end
         end
      end

      assign bus.rd_data[i*XLEN +: XLEN] = data;
      assign bus.rd_busy[i]              = bsy;
   end
endmodule
